cpu_step_ctrl: RTL
==================

Name: cpu_step_ctrl

Overview:
Debug run-control front end that sits directly upstream of the RISC-V core's HALT input in the FPGA wrapper. It debounces the board buttons and the auto-step switch, and runs a small run/halt/step state machine. It drives a single registered halt level into the core, which supports free-run, single-instruction step and slow auto-step, replacing the ad-hoc tick counter. It also reports state and a release counter for the LEDs/debug.

Parameters:
DEBOUNCE_CYCLES, 1_000_000, consecutive stable samples needed before a button/switch level is accepted (10 ms at 100 MHz)
TICK_PERIOD, 50_000_000, auto-step release interval in clock cycles (0.5 s)
CNT_W, 32, width of debounce and tick counters; must hold max(DEBOUNCE_CYCLES, TICK_PERIOD)

Ports:
CLK100MHZ  input  1  system clock
reset  input  1  asynchronous, active-high reset
btn_run  input  1  raw button, request free run
btn_step  input  1  raw button, request one-cycle release
btn_halt  input  1  raw button, request halt
sw_auto  input  1  raw switch, auto-step mode while high
cpu_halt  output  1  registered; 1 = core stalled, 0 = core advances this cycle
ctrl_state  output  2  current FSM state encoding
release_count  output  16  count of cycles with cpu_halt=0, wraps

Behaviour:
- Reset: async, active-high, one clock CLK100MHZ. While reset is high: state=HALTED; cpu_halt=1; ctrl_state=HALTED; release_count=0; all synchronisers, debounced levels, press pulses and counters=0.
- Input path: each raw input passes through a 2-flop synchroniser, then a debouncer.
- Debouncer counter rules:
  - Counter clears when the synced value equals the stable value.
  - Otherwise it increments.
  - When the counter is DEBOUNCE_CYCLES-1 and the synced value still differs, the stable value takes the synced value and the counter clears.
- Press pulses: a rising edge of a stable button level gives a registered 1-cycle press pulse. Falling edges give none. sw_auto is used as its stable level.
- Latency: raw button high first sampled at edge k -> stable at edge k+DEBOUNCE_CYCLES+1 -> press at edge k+DEBOUNCE_CYCLES+2 -> cpu_halt/state update at edge k+DEBOUNCE_CYCLES+3.
- Glitches: a glitch shorter than DEBOUNCE_CYCLES never changes the stable level.
- States (2-bit): HALTED=0, RUNNING=1, STEP=2, AUTO=3.
- HALTED: cpu_halt=1. Transitions checked in priority order:
  - halt_press -> stay.
  - step_press -> STEP.
  - run_press -> RUNNING.
  - auto level high -> AUTO.
- RUNNING: cpu_halt=0 every cycle. halt_press -> HALTED. Step, run and auto are ignored.
- STEP: cpu_halt=0 for exactly one cycle, then unconditionally HALTED. Presses arriving during STEP are dropped.
- AUTO: on entry the tick counter is 0 and increments each cycle. At TICK_PERIOD-1 it wraps to 0 and cpu_halt=0 for that one cycle only; otherwise cpu_halt=1. Exits:
  - halt_press, or auto level low -> HALTED.
  - If that happens in a release cycle, the exit wins and cpu_halt=1.
  - First release comes TICK_PERIOD cycles after entry.
- Simultaneous presses: priority is halt > step > run > auto.
- Registered outputs: cpu_halt and ctrl_state are both registered and updated on the same edge. cpu_halt is never driven combinationally from inputs.
- release_count: increments by 1 on every edge where registered cpu_halt=0; wraps 0xFFFF -> 0.
- Reset mid-operation (any state, including mid-debounce or mid-tick): immediate return to reset values; no press pulse is generated on release of reset.

Decomposition:
- Shared package: state encoding constants HALTED/RUNNING/STEP/AUTO and the 2-bit state width.
- Sub-module btn_debounce (synchroniser + debounce counter + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated four times.
- FSM, tick counter and release counter stay in cpu_step_ctrl.

Test Plan:
(All scenarios use DEBOUNCE_CYCLES=4, TICK_PERIOD=8.)
1. Reset and latency: assert reset, then btn_step high for 10 cycles from edge 0 -> cpu_halt=1 until edge 7, 0 at edge 7 only, 1 from edge 8; release_count=1; ctrl_state 2 then 0.
2. Glitch rejection: btn_run high 3 cycles, then low -> no state change, cpu_halt stays 1.
3. Free run then halt: btn_run held 6 cycles -> RUNNING, cpu_halt=0 continuously. After 20 cycles btn_halt held 6 cycles -> HALTED 7 edges after press start; release_count equals the counted low cycles.
4. Auto mode: sw_auto high -> AUTO. cpu_halt=0 for exactly 1 cycle in every 8, first release 8 cycles after entry. sw_auto low -> HALTED with no further releases.
5. Simultaneous presses: btn_halt, btn_step, btn_run rise on the same cycle from HALTED -> stays HALTED. btn_step+btn_run together -> STEP, one release, then HALTED.
6. Async reset mid-RUNNING: pulse reset between clock edges -> cpu_halt=1, ctrl_state=0, release_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/cpu_step_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_step_ctrl_pkg                                            |
// | Description : Run-control state encoding shared by the step controller.   |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package cpu_step_ctrl_pkg;

    localparam int c_STATE_W = 2;

    localparam logic [c_STATE_W-1:0] c_HALTED  = 2'd0;
    localparam logic [c_STATE_W-1:0] c_RUNNING = 2'd1;
    localparam logic [c_STATE_W-1:0] c_STEP    = 2'd2;
    localparam logic [c_STATE_W-1:0] c_AUTO    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cpu_step_ctrl_btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : btn_debounce                                                 |
// | Description : 2-flop synchroniser, stability counter and rising-edge pulse.|
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CNT_W           = 32
) (
    input  logic CLK100MHZ,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_stable_d;
    logic             r_press;

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_sync     <= 2'b00;
            r_cnt      <= '0;
            r_stable   <= 1'b0;
            r_stable_d <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            // Any sample agreeing with the accepted level restarts the qualification window
            if (r_sync[1] == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync[1];
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_stable_d <= r_stable;
            r_press    <= r_stable & ~r_stable_d;
        end
    end

    assign level = r_stable;
    assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/cpu_step_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : cpu_step_ctrl                                                |
// | Description : Debounced run/halt/step/auto-step control of the core HALT.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
module cpu_step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int TICK_PERIOD     = 50_000_000,
    parameter int CNT_W           = 32
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_step,
    input  logic        btn_halt,
    input  logic        sw_auto,
    output logic        cpu_halt,
    output logic [1:0]  ctrl_state,
    output logic [15:0] release_count
);

    import cpu_step_ctrl_pkg::*;

    localparam logic [CNT_W-1:0] c_TICK_LAST = CNT_W'(TICK_PERIOD - 1);

    logic                 w_run_press;
    logic                 w_step_press;
    logic                 w_halt_press;
    logic                 w_auto_level;
    logic [3:0]           w_unused_debounce;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_state_nxt;
    logic                 r_halt;
    logic                 w_halt_nxt;
    logic [CNT_W-1:0]     r_tick;
    logic [CNT_W-1:0]     w_tick_nxt;
    logic [15:0]          r_release_count;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_run (
        .CLK100MHZ (CLK100MHZ), .reset (reset), .raw (btn_run),
        .level (w_unused_debounce[0]), .press (w_run_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_step (
        .CLK100MHZ (CLK100MHZ), .reset (reset), .raw (btn_step),
        .level (w_unused_debounce[1]), .press (w_step_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_halt (
        .CLK100MHZ (CLK100MHZ), .reset (reset), .raw (btn_halt),
        .level (w_unused_debounce[2]), .press (w_halt_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db_auto (
        .CLK100MHZ (CLK100MHZ), .reset (reset), .raw (sw_auto),
        .level (w_auto_level), .press (w_unused_debounce[3])
    );

    // Halt is held by default; each branch only opens it for the cycle that releases the core
    always_comb begin
        w_state_nxt = r_state;
        w_halt_nxt  = 1'b1;
        w_tick_nxt  = '0;
        case (r_state)
            c_HALTED: begin
                if (w_halt_press) begin
                    w_state_nxt = c_HALTED;
                end else if (w_step_press) begin
                    w_state_nxt = c_STEP;
                    w_halt_nxt  = 1'b0;
                end else if (w_run_press) begin
                    w_state_nxt = c_RUNNING;
                    w_halt_nxt  = 1'b0;
                end else if (w_auto_level) begin
                    w_state_nxt = c_AUTO;
                end
            end
            c_RUNNING: begin
                if (w_halt_press) begin
                    w_state_nxt = c_HALTED;
                end else begin
                    w_halt_nxt = 1'b0;
                end
            end
            c_STEP: begin
                w_state_nxt = c_HALTED;
            end
            c_AUTO: begin
                if (w_halt_press || !w_auto_level) begin
                    w_state_nxt = c_HALTED;
                end else if (r_tick == c_TICK_LAST) begin
                    w_halt_nxt = 1'b0;
                end else begin
                    w_tick_nxt = r_tick + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            r_state         <= c_HALTED;
            r_halt          <= 1'b1;
            r_tick          <= '0;
            r_release_count <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_halt  <= w_halt_nxt;
            r_tick  <= w_tick_nxt;
            if (!r_halt) begin
                r_release_count <= r_release_count + 16'd1;
            end
        end
    end

    assign cpu_halt      = r_halt;
    assign ctrl_state    = r_state;
    assign release_count = r_release_count;

endmodule
`default_nettype wire
